// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and Gray/binary pointer conversions.
// Used by both the read-side and the write-side pointer blocks.
package fifo_pkg;

  localparam int unsigned FifoDataSize = 8;
  localparam int unsigned FifoAddrSize = 4;

  // Conversions work on a 32-bit container. Callers zero-extend the pointer and
  // cast the result back to pointer width. Zero upper bits do not change the
  // low bits in either direction.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Reset is synchronous and active-high, and it clears both stages.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Capture the asynchronous input, then give it a full cycle to settle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side controller. It synchronizes the write Gray pointer,
// keeps the binary read pointer, and produces a registered empty flag and
// registered read data.
// Optional build macro FIFO_ALMOST_EMPTY_EN adds the o_almost_empty output.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = FifoDataSize,
  parameter int unsigned ADDR_SIZE = FifoAddrSize,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                 i_rd_clk,
  input  logic                 i_rd_rst,
  input  logic                 i_rd_en,
  input  logic [ADDR_SIZE:0]   i_wptr_gray,
  input  logic [DATA_SIZE-1:0] i_rd_data,
  output logic [ADDR_SIZE-1:0] o_rd_addr,
  output logic [ADDR_SIZE:0]   o_rptr_gray,
  output logic                 o_empty,
  output logic [DATA_SIZE-1:0] o_dout,
  output logic                 o_dout_valid,
  output logic                 o_underflow
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic                 o_almost_empty
`endif
);

  localparam int unsigned PtrW = ADDR_SIZE + 1;

  logic [PtrW-1:0]      wq2_wptr;
  logic [PtrW-1:0]      rbin_q, rbin_d;
  logic [PtrW-1:0]      rptr_gray_q, rptr_gray_d;
  logic                 empty_q, empty_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 dout_valid_q;
  logic                 underflow_q;
  logic                 accepted;

  sync_2ff #(
    .Width(PtrW)
  ) u_wptr_sync (
    .clk_i(i_rd_clk),
    .rst_i(i_rd_rst),
    .d_i  (i_wptr_gray),
    .q_o  (wq2_wptr)
  );

  // Next read pointer and flags. Empty compares the post-read pointer, so
  // draining the last word raises empty on the following cycle.
  always_comb begin
    accepted    = i_rd_en & ~empty_q;
    rbin_d      = rbin_q + PtrW'(accepted);
    rptr_gray_d = PtrW'(bin2gray(32'(rbin_d)));
    empty_d     = (rptr_gray_d == wq2_wptr);
    dout_d      = accepted ? i_rd_data : dout_q;
  end

  // Pointer, flag and data registers. Reset takes priority over a pending read.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      rbin_q       <= '0;
      rptr_gray_q  <= '0;
      empty_q      <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_gray_q  <= rptr_gray_d;
      empty_q      <= empty_d;
      dout_q       <= dout_d;
      dout_valid_q <= accepted;
      underflow_q  <= i_rd_en & empty_q;
    end
  end

  assign o_rd_addr    = rbin_q[ADDR_SIZE-1:0];
  assign o_rptr_gray  = rptr_gray_q;
  assign o_empty      = empty_q;
  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_underflow  = underflow_q;

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [PtrW-1:0] wbin;
  logic [PtrW-1:0] level;
  logic            almost_empty_q, almost_empty_d;

  // Fill level uses the same post-read pointer as empty, so the two flags stay consistent.
  always_comb begin
    wbin           = PtrW'(gray2bin(32'(wq2_wptr)));
    level          = wbin - rbin_d;
    almost_empty_d = (32'(level) <= AE_THRESH);
  end

  // Almost-empty register. Reset reports the FIFO as empty.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end

  assign o_almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_SIZE=4, DATA_SIZE=8). A count-based
// occupancy model runs alongside the directed stimulus. Literal checks pin down
// the key latencies.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [4:0] wcnt;
  logic [4:0] wptr_gray;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic [4:0] rptr_gray;
  logic       empty;
  logic [7:0] dout;
  logic       dout_valid;
  logic       underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wptr_gray = gray(wcnt);
  assign rd_data   = mem[rd_addr];

  fifo_rd_ctrl #(
    .DATA_SIZE(8),
    .ADDR_SIZE(4),
    .AE_THRESH(2)
  ) dut (
    .i_rd_clk      (clk),
    .i_rd_rst      (rst),
    .i_rd_en       (rd_en),
    .i_wptr_gray   (wptr_gray),
    .i_rd_data     (rd_data),
    .o_rd_addr     (rd_addr),
    .o_rptr_gray   (rptr_gray),
    .o_empty       (empty),
    .o_dout        (dout),
    .o_dout_valid  (dout_valid),
    .o_underflow   (underflow)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .o_almost_empty(almost_empty)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state. The write count is seen through a two-edge delay. Counts are mod 32.
  logic [4:0] m_rcnt, m_wd1, m_wd2, m_level;
  logic       m_empty, m_valid, m_uf, m_ae;
  logic [7:0] m_dout;

  always @(posedge clk) begin
    logic       acc;
    logic [4:0] rnext;
    if (rst) begin
      m_rcnt  = 0;
      m_wd1   = 0;
      m_wd2   = 0;
      m_empty = 1'b1;
      m_valid = 1'b0;
      m_uf    = 1'b0;
      m_dout  = 8'h00;
      m_ae    = 1'b1;
    end else begin
      acc     = rd_en && !m_empty;
      m_uf    = rd_en && m_empty;
      m_valid = acc;
      if (acc) m_dout = mem[m_rcnt[3:0]];
      rnext   = m_rcnt + 5'(acc);
      m_empty = (rnext == m_wd2);
      m_level = m_wd2 - rnext;
      m_ae    = (m_level <= 5'd2);
      m_wd2   = m_wd1;
      m_wd1   = wcnt;
      m_rcnt  = rnext;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("m_empty", 32'(empty), 32'(m_empty));
    chk("m_rptr_gray", 32'(rptr_gray), 32'(gray(m_rcnt)));
    chk("m_rd_addr", 32'(rd_addr), 32'(m_rcnt[3:0]));
    chk("m_dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("m_dout", 32'(dout), 32'(m_dout));
    chk("m_underflow", 32'(underflow), 32'(m_uf));
`ifdef FIFO_ALMOST_EMPTY_EN
    chk("m_almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'hA5;
    rst   = 1'b1;
    rd_en = 1'b0;
    wcnt  = 5'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rptr", 32'(rptr_gray), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
`ifdef FIFO_ALMOST_EMPTY_EN
    chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
    rst  = 1'b0;
    wcnt = 5'd1;

    // Empty deasserts on exactly the third edge after the pointer changes.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("empty_lat_edge%0d", k), 32'(empty), (k < 3) ? 32'd1 : 32'd0);
    end

    wcnt = 5'd2;
    @(negedge clk);
    wcnt = 5'd3;
    repeat (4) @(negedge clk);
    chk("pre_read_empty", 32'(empty), 32'd0);
    chk("pre_read_rptr", 32'(rptr_gray), 32'd0);
`ifdef FIFO_ALMOST_EMPTY_EN
    chk("ae_level3", 32'(almost_empty), 32'd0);
`endif

    // First read returns the word at address 0 one cycle later.
    rd_en = 1'b1;
    @(negedge clk);
    chk("rd_dout", 32'(dout), 32'hA5);
    chk("rd_valid", 32'(dout_valid), 32'd1);
    chk("rd_rptr", 32'(rptr_gray), 32'b00001);
`ifdef FIFO_ALMOST_EMPTY_EN
    chk("ae_level2", 32'(almost_empty), 32'd1);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_rptr", 32'(rptr_gray), 32'b00010);
    @(negedge clk);
    chk("uf_pulse", 32'(underflow), 32'd1);
    chk("uf_valid", 32'(dout_valid), 32'd0);
    chk("uf_rptr_held", 32'(rptr_gray), 32'b00010);
    chk("uf_addr_held", 32'(rd_addr), 32'd3);
    chk("uf_dout_held", 32'(dout), 32'(mem[2]));
    rd_en = 1'b0;
    @(negedge clk);
    chk("uf_clear", 32'(underflow), 32'd0);

    // Refill, then assert reset together with a read. The read is discarded.
    wcnt = 5'd5;
    repeat (4) @(negedge clk);
    chk("refill_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    rst   = 1'b1;
    wcnt  = 5'd0;
    @(negedge clk);
    chk("rstrd_valid", 32'(dout_valid), 32'd0);
    chk("rstrd_empty", 32'(empty), 32'd1);
    chk("rstrd_rptr", 32'(rptr_gray), 32'd0);
    chk("rstrd_dout", 32'(dout), 32'd0);
    rst   = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);

    // 32 write/read pairs walk the pointer through both laps and back to zero.
    for (int i = 0; i < 32; i++) begin
      wcnt = wcnt + 5'd1;
      repeat (3) @(negedge clk);
      chk($sformatf("wrap_addr%0d", i), 32'(rd_addr), 32'(i % 16));
      chk($sformatf("wrap_ne%0d", i), 32'(empty), 32'd0);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk($sformatf("wrap_dout%0d", i), 32'(dout), 32'(mem[i % 16]));
      chk($sformatf("wrap_empty%0d", i), 32'(empty), 32'd1);
    end
    chk("wrap_rptr_zero", 32'(rptr_gray), 32'd0);
    repeat (2) @(negedge clk);
    chk("wrap_still_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: width of each FIFO word.
REQ-002 SHALL have parameter ADDR_SIZE, default 4: memory address width; depth = 2**ADDR_SIZE.
REQ-003 SHALL have parameter AE_THRESH, default 2: almost-empty level in words; used only when FIFO_ALMOST_EMPTY_EN is defined.
REQ-004 SHALL have port i_rd_clk, input, 1: read-domain clock; the only clock.
REQ-005 SHALL have port i_rd_rst, input, 1: reset, synchronous to i_rd_clk, active-high.
REQ-006 SHALL have port i_rd_en, input, 1: consumer read request.
REQ-007 SHALL have port i_wptr_gray, input, ADDR_SIZE+1: write-domain Gray pointer, asynchronous to i_rd_clk.
REQ-008 SHALL have port i_rd_data, input, DATA_SIZE: combinational memory read data for o_rd_addr.
REQ-009 SHALL have port o_rd_addr, output, ADDR_SIZE: memory read address.
REQ-010 SHALL have port o_rptr_gray, output, ADDR_SIZE+1: registered Gray read pointer for the write domain.
REQ-011 SHALL have port o_empty, output, 1: registered empty flag.
REQ-012 SHALL have port o_dout, output, DATA_SIZE: registered read data.
REQ-013 SHALL have port o_dout_valid, output, 1: o_dout carries a newly accepted word this cycle.
REQ-014 SHALL have port o_underflow, output, 1: one-cycle pulse when i_rd_en is asserted while o_empty=1.
REQ-015 SHALL have port o_almost_empty, output, 1: present only when FIFO_ALMOST_EMPTY_EN is defined.

Function
REQ-016 SHALL pass i_wptr_gray through a two-stage flop synchronizer; the second stage output is wq2_wptr.
REQ-017 SHALL hold an ADDR_SIZE+1-bit binary read counter rbin; read accepted = i_rd_en & ~o_empty; rbin_next = rbin + accepted, modulo 2**(ADDR_SIZE+1).
REQ-018 SHALL register o_rptr_gray = rbin_next ^ (rbin_next >> 1); o_rd_addr = rbin[ADDR_SIZE-1:0].
REQ-019 SHALL register o_empty = (Gray of rbin_next == wq2_wptr).
REQ-020 SHALL, on an accepted read in cycle N, load o_dout <= i_rd_data and set o_dout_valid=1 in cycle N+1; otherwise o_dout holds its value and o_dout_valid=0.
REQ-021 SHALL ignore a read while empty: rbin, o_rptr_gray and o_dout are unchanged; o_underflow=1 in the next cycle.
REQ-022 SHALL wrap rbin from 2**(ADDR_SIZE+1)-1 to 0 without a flag glitch; the MSB distinguishes laps.
REQ-023 SHALL deassert o_empty no earlier than 3 i_rd_clk edges after i_wptr_gray changes (2 sync + 1 flag register).
REQ-024 SHALL, when a read accepts the last word, assert o_empty in the next cycle, even if a write pointer update is still in the synchronizer.

Reset
REQ-025 SHALL, on i_rd_rst=1 at a clock edge, clear rbin, o_rptr_gray, o_rd_addr, both synchronizer stages, o_dout, o_dout_valid and o_underflow to 0, and set o_empty=1 (and o_almost_empty=1).
REQ-026 SHALL give reset priority over an accepted read in the same cycle; a read in progress is discarded.

Configuration
REQ-027 SHALL, when macro FIFO_ALMOST_EMPTY_EN is defined, convert wq2_wptr to binary, compute level = wbin - rbin_next (ADDR_SIZE+1 bits), and register o_almost_empty = (level <= AE_THRESH).
REQ-028 SHALL, when FIFO_ALMOST_EMPTY_EN is undefined, omit o_almost_empty and the Gray-to-binary logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the bin2gray and gray2bin functions, and the default ADDR_SIZE/DATA_SIZE constants, in the shared package fifo_pkg used with the write-side blocks.
REQ-030 SHALL instantiate one sub-module, sync_2ff (parameterized width, reset per REQ-025), for the pointer synchronizer.

Verification (ADDR_SIZE=4, DATA_SIZE=8)
REQ-031 SHALL check reset: pulse i_rd_rst -> o_empty=1, o_rptr_gray=0, o_dout_valid=0, o_almost_empty=1.
REQ-032 SHALL check empty latency: after reset, drive i_wptr_gray=5'b00001 -> o_empty=0 exactly on the 3rd edge.
REQ-033 SHALL check read latency: with i_wptr_gray=Gray(3) and i_rd_data=8'hA5, one read -> next cycle o_dout=8'hA5, o_dout_valid=1, o_rptr_gray=5'b00001.
REQ-034 SHALL check drain and underflow: read 3 words, then hold i_rd_en -> o_empty=1 after the 3rd read, then o_underflow=1 with rbin held at 3.
REQ-035 SHALL check wrap: complete 32 write/read pairs -> o_rptr_gray returns to 0, o_rd_addr sequence is 0..15 twice, and no spurious o_empty deassertion occurs.
REQ-036 SHALL check, with FIFO_ALMOST_EMPTY_EN defined and AE_THRESH=2, that level 3 gives o_almost_empty=0 and one read to level 2 gives 1.
